// File: rtl/conv_frame_scheduler.sv
// conv_frame_scheduler: one-frame sequencer for the line-buffer/3x3 conv path.
// Packs 4-bit results three per 12-bit word and streams them to the frame RAM.
`timescale 1ns/1ps
`default_nettype none

module conv_frame_scheduler #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 478,
    parameter int AW    = 17
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ctrl_done,
    input  logic          pix_valid,
    input  logic [3:0]    pix_in,
    output logic          conv_en,
    output logic          wr_en,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [11:0]   wr_data,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);

    localparam int            TOTAL   = IMG_W * IMG_H;
    localparam int            CW      = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] LAST_IX = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [CW-1:0] pix_cnt;
    logic [1:0]    nib_cnt;
    logic [11:0]   pack;
    logic          skid_valid;
    logic [11:0]   skid_data;

    logic          start_acc;
    logic          pix_acc;
    logic          last_pix;
    logic          early_done;
    logic          out_free;
    logic          push_ok;
    logic          push_valid;
    logic [11:0]   push_data;
    logic          flush_empty;

    assign start_acc   = (state == S_IDLE) && start;
    assign pix_acc     = (state == S_RUN) && pix_valid;
    assign last_pix    = pix_acc && (pix_cnt == LAST_IX);
    assign early_done  = (state == S_RUN) && ctrl_done && !last_pix;
    assign out_free    = !wr_en || wr_ready;
    assign push_ok     = out_free || !skid_valid;
    assign flush_empty = (nib_cnt == 2'd0) && !skid_valid && !wr_en;

    // A word is pushed either when the third nibble arrives or, in FLUSH,
    // as a zero-padded partial word built from whatever nibbles are held.
    always_comb begin
        push_valid = 1'b0;
        push_data  = {pack[11:4], pix_in};
        if (state == S_RUN) begin
            push_valid = pix_acc && (nib_cnt == 2'd2);
        end else if (state == S_FLUSH) begin
            push_valid = (nib_cnt != 2'd0);
            push_data  = pack;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        conv_en    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                conv_en = !skid_valid && !(wr_en && !wr_ready);
                if (last_pix || ctrl_done) begin
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (flush_empty) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Packer and pixel counter
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            nib_cnt <= 2'd0;
            pack    <= 12'h000;
            err     <= 1'b0;
        end else if (start_acc) begin
            pix_cnt <= '0;
            nib_cnt <= 2'd0;
            pack    <= 12'h000;
            err     <= 1'b0;
        end else begin
            if (pix_acc) begin
                pix_cnt <= pix_cnt + 1'b1;
                case (nib_cnt)
                    2'd0: begin
                        pack    <= {pix_in, 8'h00};
                        nib_cnt <= 2'd1;
                    end
                    2'd1: begin
                        pack[7:4] <= pix_in;
                        nib_cnt   <= 2'd2;
                    end
                    default: begin
                        pack    <= 12'h000;
                        nib_cnt <= 2'd0;
                    end
                endcase
            end
            if ((state == S_FLUSH) && push_valid && push_ok) begin
                pack    <= 12'h000;
                nib_cnt <= 2'd0;
            end
            if (early_done) begin
                err <= 1'b1;
            end
        end
    end

    // Output register plus one-word skid; the skid always drains first so
    // words leave in the order they were packed.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_data    <= 12'h000;
            wr_addr    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= 12'h000;
        end else if (start_acc) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            skid_valid <= 1'b0;
        end else begin
            if (wr_en && wr_ready) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (out_free) begin
                if (skid_valid) begin
                    wr_en      <= 1'b1;
                    wr_data    <= skid_data;
                    skid_valid <= push_valid;
                    if (push_valid) begin
                        skid_data <= push_data;
                    end
                end else begin
                    wr_en <= push_valid;
                    if (push_valid) begin
                        wr_data <= push_data;
                    end
                end
            end else if (push_valid && !skid_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= push_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_scheduler.sv
// tb_conv_frame_scheduler: directed checks of packing, flush, backpressure,
// early ctrl_done, async reset and start-while-busy.
`timescale 1ns/1ps
`default_nettype none

module tb_conv_frame_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        ctrl_done;
    logic        pix_valid;
    logic [3:0]  pix_in;
    logic        wr_ready;
    logic        sel;

    logic        start_a;
    logic        start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic        a_conv_en, a_wr_en, a_busy, a_frame_done, a_err;
    logic [16:0] a_wr_addr;
    logic [11:0] a_wr_data;
    logic        b_conv_en, b_wr_en, b_busy, b_frame_done, b_err;
    logic [16:0] b_wr_addr;
    logic [11:0] b_wr_data;

    conv_frame_scheduler #(.IMG_W(4), .IMG_H(3), .AW(17)) u_dut (
        .pixel_clk (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .ctrl_done (ctrl_done),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .conv_en   (a_conv_en),
        .wr_en     (a_wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (a_wr_addr),
        .wr_data   (a_wr_data),
        .busy      (a_busy),
        .frame_done(a_frame_done),
        .err       (a_err)
    );

    conv_frame_scheduler #(.IMG_W(5), .IMG_H(1), .AW(17)) u_dut5 (
        .pixel_clk (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .ctrl_done (ctrl_done),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .conv_en   (b_conv_en),
        .wr_en     (b_wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (b_wr_addr),
        .wr_data   (b_wr_data),
        .busy      (b_busy),
        .frame_done(b_frame_done),
        .err       (b_err)
    );

    logic        m_conv_en, m_wr_en, m_busy, m_frame_done, m_err;
    logic [16:0] m_wr_addr;
    logic [11:0] m_wr_data;
    assign m_conv_en    = sel ? b_conv_en    : a_conv_en;
    assign m_wr_en      = sel ? b_wr_en      : a_wr_en;
    assign m_busy       = sel ? b_busy       : a_busy;
    assign m_frame_done = sel ? b_frame_done : a_frame_done;
    assign m_err        = sel ? b_err        : a_err;
    assign m_wr_addr    = sel ? b_wr_addr    : a_wr_addr;
    assign m_wr_data    = sel ? b_wr_data    : a_wr_data;

    int          errors = 0;
    int          checks = 0;

    logic [3:0]  vals [16];
    logic [11:0] wd [8];
    int          wa [8];
    int          nw;
    int          fd_cnt;
    int          fd_cyc;
    logic        timed_out;
    logic        busy_k1, err_k1, busy_end, err_end;
    logic        pre_wr_en;
    logic [11:0] pre_wr_data;
    logic        en_log [80];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_conv_en"},    32'(m_conv_en),    32'd0);
        chk({tag, "_wr_en"},      32'(m_wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(m_wr_addr),    32'd0);
        chk({tag, "_wr_data"},    32'(m_wr_data),    32'd0);
        chk({tag, "_busy"},       32'(m_busy),       32'd0);
        chk({tag, "_frame_done"}, 32'(m_frame_done), 32'd0);
        chk({tag, "_err"},        32'(m_err),        32'd0);
    endtask

    task automatic chk_words(input string tag, input int n, input logic [11:0] e0,
                             input logic [11:0] e1, input logic [11:0] e2, input logic [11:0] e3);
        logic [11:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
        chk({tag, "_nwords"}, 32'(nw), 32'(n));
        for (int i = 0; i < n && i < nw; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(e[i]));
            chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(i));
        end
    endtask

    // One frame: the source presents a pixel when conv_en was high the
    // previous cycle; the first force_n pixels are presented unconditionally
    // from cycle 2 to model results already in the conv pipeline.
    task automatic run_frame(input logic s5, input int npix, input int force_n,
                             input int stall_from, input int stall_len,
                             input int start2_a, input int start2_b, input int rst_at);
        int   idx;
        int   cyc;
        logic en_prev;
        logic cd_sent;
        logic fin;
        logic pv;
        idx = 0; cyc = 0; en_prev = 1'b0; cd_sent = 1'b0; fin = 1'b0;
        sel = s5; nw = 0; fd_cnt = 0; fd_cyc = -1; timed_out = 1'b0;
        busy_end = 1'b0; err_end = 1'b0; busy_k1 = 1'b0; err_k1 = 1'b0;
        for (int i = 0; i < 80; i++) en_log[i] = 1'b0;
        while (!fin) begin
            start = (cyc == 0) || (cyc == start2_a) || (cyc == start2_b);
            pv = (idx < npix) && (en_prev || (cyc >= 2 && idx < force_n));
            pix_valid = pv;
            pix_in = pv ? vals[idx] : 4'h0;
            if (pv) idx++;
            ctrl_done = !pv && (idx == npix) && !cd_sent && (cyc >= 2);
            if (ctrl_done) cd_sent = 1'b1;
            wr_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            #1;
            if (cyc == 1) begin
                busy_k1 = m_busy;
                err_k1  = m_err;
            end
            en_log[cyc] = m_conv_en;
            en_prev = m_conv_en;
            if (m_wr_en && wr_ready && nw < 8) begin
                wd[nw] = m_wr_data;
                wa[nw] = int'(m_wr_addr);
                nw++;
            end
            if (m_frame_done) begin
                fd_cnt++;
                if (fd_cyc < 0) fd_cyc = cyc;
                err_end = m_err;
            end
            if (cyc == rst_at) begin
                pre_wr_en   = m_wr_en;
                pre_wr_data = m_wr_data;
                rst_n = 1'b0;
                #1;
                fin = 1'b1;
            end else if (fd_cyc >= 0 && cyc == fd_cyc + 3) begin
                busy_end = m_busy;
                fin = 1'b1;
            end else if (cyc == 79) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end
            if (cyc != rst_at) @(negedge clk);
            cyc++;
        end
        start = 1'b0; pix_valid = 1'b0; ctrl_done = 1'b0; wr_ready = 1'b1; pix_in = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ctrl_done = 1'b0; pix_valid = 1'b0;
        pix_in = 4'h0; wr_ready = 1'b1; sel = 1'b0;
        pre_wr_en = 1'b0; pre_wr_data = 12'h0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Plain 4x3 frame, pixels 1..12
        for (int i = 0; i < 16; i++) vals[i] = 4'(i + 1);
        run_frame(1'b0, 12, 0, 0, 0, -1, -1, -1);
        chk_words("s1", 4, 12'h123, 12'h456, 12'h789, 12'hABC);
        chk("s1_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("s1_fd_cyc", 32'(fd_cyc), 32'd16);
        chk("s1_err", 32'(err_end), 32'd0);
        chk("s1_busy_k1", 32'(busy_k1), 32'd1);
        chk("s1_en_k1", 32'(en_log[1]), 32'd1);
        chk("s1_en_k14", 32'(en_log[14]), 32'd0);
        chk("s1_busy_end", 32'(busy_end), 32'd0);

        // 5x1 frame with padded final word
        vals[0] = 4'hF; vals[1] = 4'hE; vals[2] = 4'hD; vals[3] = 4'hC; vals[4] = 4'hB;
        run_frame(1'b1, 5, 0, 0, 0, -1, -1, -1);
        chk_words("s2", 2, 12'hFED, 12'hCB0, 12'h000, 12'h000);
        chk("s2_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("s2_fd_cyc", 32'(fd_cyc), 32'd10);

        // Backpressure: six stalled cycles; second word lands in the skid
        for (int i = 0; i < 16; i++) vals[i] = 4'(i + 1);
        run_frame(1'b0, 12, 6, 5, 6, -1, -1, -1);
        chk_words("s3", 4, 12'h123, 12'h456, 12'h789, 12'hABC);
        chk("s3_en_k5", 32'(en_log[5]), 32'd0);
        chk("s3_en_k8", 32'(en_log[8]), 32'd0);
        chk("s3_en_k11", 32'(en_log[11]), 32'd0);
        chk("s3_en_k12", 32'(en_log[12]), 32'd1);
        chk("s3_fd_cyc", 32'(fd_cyc), 32'd21);
        chk("s3_err", 32'(err_end), 32'd0);

        // Early ctrl_done after 7 pixels
        run_frame(1'b0, 7, 0, 0, 0, -1, -1, -1);
        chk_words("s4", 3, 12'h123, 12'h456, 12'h700, 12'h000);
        chk("s4_err", 32'(err_end), 32'd1);
        chk("s4_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("s4_fd_cyc", 32'(fd_cyc), 32'd13);

        // Reset while wr_en is high and the skid is full
        run_frame(1'b0, 12, 6, 5, 6, -1, -1, 9);
        chk("s5_err_cleared", 32'(err_k1), 32'd0);
        chk("s5_pre_wr_en", 32'(pre_wr_en), 32'd1);
        chk("s5_pre_wr_data", 32'(pre_wr_data), 32'h123);
        chk("s5_pre_en_k9", 32'(en_log[9]), 32'd0);
        chk_zero("s5_async");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_frame(1'b0, 12, 0, 0, 0, -1, -1, -1);
        chk_words("s5_clean", 4, 12'h123, 12'h456, 12'h789, 12'hABC);
        chk("s5_fd_cyc", 32'(fd_cyc), 32'd16);

        // start while busy (mid-frame and during the frame_done cycle)
        run_frame(1'b0, 12, 0, 0, 0, 5, 16, -1);
        chk_words("s6", 4, 12'h123, 12'h456, 12'h789, 12'hABC);
        chk("s6_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("s6_fd_cyc", 32'(fd_cyc), 32'd16);
        chk("s6_busy_end", 32'(busy_end), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
